// File: rtl/store_commit_issue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_commit_issue_pkg                                               |
// | Shared types for the store-commit issue stage.                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package store_commit_issue_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } store_size_e;

  typedef enum logic [1:0] {
    UC_IDLE  = 2'd0,
    UC_DRAIN = 2'd1,
    UC_REQ   = 2'd2,
    UC_RESP  = 2'd3
  } uc_state_e;

  localparam int C_PADDR_SIZE  = 32;
  localparam int C_DCACHE_BYTE = 4;

  typedef struct packed {
    logic [C_PADDR_SIZE-$clog2(C_DCACHE_BYTE)-1:0] addr;
    logic [C_DCACHE_BYTE-1:0]                      mask;
    logic [8*C_DCACHE_BYTE-1:0]                    data;
  } aligned_store_t;

  // Byte-enable pattern for an access of the given size, before shifting.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_commit_issue_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_commit_issue_align                                             |
// | Converts a byte-addressed store into word address, mask and data.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module store_commit_issue_align
  import store_commit_issue_pkg::*;
#(
  parameter  int PADDR_SIZE  = 32,
  parameter  int DCACHE_BYTE = 4,
  localparam int BW          = $clog2(DCACHE_BYTE),
  localparam int DB          = 8*DCACHE_BYTE
) (
  input  logic [PADDR_SIZE-1:0]    paddr,
  input  logic [1:0]               size,
  input  logic [DB-1:0]            data_in,
  output logic [PADDR_SIZE-BW-1:0] addr,
  output logic [DCACHE_BYTE-1:0]   mask,
  output logic [DB-1:0]            data_out
);

  logic [BW-1:0]          w_off;
  logic [DCACHE_BYTE-1:0] w_base;

  assign w_off  = paddr[BW-1:0];
  assign w_base = DCACHE_BYTE'(size_mask(size));

  // Lanes shifted beyond the word fall off the top of the fixed width.
  assign addr     = paddr[PADDR_SIZE-1:BW];
  assign mask     = w_base << w_off;
  assign data_out = data_in << {w_off, 3'b000};

endmodule
`default_nettype wire

// File: rtl/store_commit_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | store_commit_issue                                                   |
// | Dequeues committed stores into the commit buffer; with macro         |
// | UNCACHE_STORE_EN, uncached stores go out through a drain/request FSM.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module store_commit_issue
  import store_commit_issue_pkg::*;
#(
  parameter  int STORE_PIPELINE    = 2,
  parameter  int PADDR_SIZE        = 32,
  parameter  int DCACHE_BYTE       = 4,
  localparam int DCACHE_BITS       = 8*DCACHE_BYTE,
  localparam int DCACHE_BYTE_WIDTH = $clog2(DCACHE_BYTE),
  localparam int AW                = PADDR_SIZE-DCACHE_BYTE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [STORE_PIPELINE-1:0]           sq_valid,
  input  logic [STORE_PIPELINE*PADDR_SIZE-1:0] sq_paddr,
  input  logic [STORE_PIPELINE*2-1:0]         sq_size,
  input  logic [STORE_PIPELINE*DCACHE_BITS-1:0] sq_data,
  input  logic [STORE_PIPELINE-1:0]           sq_uncache,
  output logic [STORE_PIPELINE-1:0]           sq_deq,
  output logic [STORE_PIPELINE-1:0]           sc_en,
  output logic [STORE_PIPELINE*AW-1:0]        sc_addr,
  output logic [STORE_PIPELINE*DCACHE_BYTE-1:0] sc_mask,
  output logic [STORE_PIPELINE*DCACHE_BITS-1:0] sc_data,
  output logic [STORE_PIPELINE-1:0]           sc_uncache,
  input  logic                                sc_conflict,
  input  logic                                sb_empty,
  output logic                                uc_req,
  output logic [PADDR_SIZE-1:0]               uc_addr,
  output logic [DCACHE_BYTE-1:0]              uc_mask,
  output logic [DCACHE_BITS-1:0]              uc_data,
  input  logic                                uc_ready,
  input  logic                                uc_resp
);

  logic [STORE_PIPELINE*AW-1:0]          w_al_addr;
  logic [STORE_PIPELINE*DCACHE_BYTE-1:0] w_al_mask;
  logic [STORE_PIPELINE*DCACHE_BITS-1:0] w_al_data;
  logic [STORE_PIPELINE-1:0]             w_unc;
  logic [STORE_PIPELINE-1:0]             w_deq;
  logic                                  w_idle;

  logic [STORE_PIPELINE-1:0]             r_sc_en;
  logic [STORE_PIPELINE*AW-1:0]          r_sc_addr;
  logic [STORE_PIPELINE*DCACHE_BYTE-1:0] r_sc_mask;
  logic [STORE_PIPELINE*DCACHE_BITS-1:0] r_sc_data;

  generate
    for (genvar gi = 0; gi < STORE_PIPELINE; gi++) begin : g_align
      store_commit_issue_align #(
        .PADDR_SIZE  (PADDR_SIZE),
        .DCACHE_BYTE (DCACHE_BYTE)
      ) u_align (
        .paddr    (sq_paddr[gi*PADDR_SIZE +: PADDR_SIZE]),
        .size     (sq_size[gi*2 +: 2]),
        .data_in  (sq_data[gi*DCACHE_BITS +: DCACHE_BITS]),
        .addr     (w_al_addr[gi*AW +: AW]),
        .mask     (w_al_mask[gi*DCACHE_BYTE +: DCACHE_BYTE]),
        .data_out (w_al_data[gi*DCACHE_BITS +: DCACHE_BITS])
      );
    end
  endgenerate

  // Slot 0 may be uncached (it feeds the FSM); an uncached entry anywhere
  // else, or behind an uncached slot 0, blocks the rest of the cycle.
  always_comb begin
    w_deq    = '0;
    w_deq[0] = w_idle & ~sc_conflict & sq_valid[0];
    for (int i = 1; i < STORE_PIPELINE; i++) begin
      w_deq[i] = w_deq[i-1] & ~w_unc[i-1] & sq_valid[i] & ~w_unc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc_en <= '0;
    end else if (!sc_conflict) begin
      r_sc_en <= w_deq & ~w_unc;
    end
  end

  always_ff @(posedge clk) begin
    if (!sc_conflict) begin
      r_sc_addr <= w_al_addr;
      r_sc_mask <= w_al_mask;
      r_sc_data <= w_al_data;
    end
  end

  assign sq_deq     = w_deq;
  assign sc_en      = r_sc_en;
  assign sc_addr    = r_sc_addr;
  assign sc_mask    = r_sc_mask;
  assign sc_data    = r_sc_data;
  assign sc_uncache = '0;

`ifdef UNCACHE_STORE_EN
  localparam logic [1:0] c_IDLE  = UC_IDLE;
  localparam logic [1:0] c_DRAIN = UC_DRAIN;
  localparam logic [1:0] c_REQ   = UC_REQ;
  localparam logic [1:0] c_RESP  = UC_RESP;

  logic [1:0]             r_state;
  logic [1:0]             r_drain_cnt;
  logic                   r_uc_req;
  logic [PADDR_SIZE-1:0]  r_uc_addr;
  logic [DCACHE_BYTE-1:0] r_uc_mask;
  logic [DCACHE_BITS-1:0] r_uc_data;
  logic                   w_uc_take;
  logic                   w_drain_ok;

  assign w_unc      = sq_uncache;
  assign w_idle     = (r_state == c_IDLE);
  assign w_uc_take  = w_deq[0] & w_unc[0];
  assign w_drain_ok = sb_empty & ~|r_sc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_drain_cnt <= 2'd0;
      r_uc_req    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_drain_cnt <= 2'd0;
          if (w_uc_take) r_state <= c_DRAIN;
        end
        c_DRAIN: begin
          if (!w_drain_ok) begin
            r_drain_cnt <= 2'd0;
          end else if (r_drain_cnt == 2'd1) begin
            r_drain_cnt <= 2'd0;
            r_uc_req    <= 1'b1;
            r_state     <= c_REQ;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        c_REQ: begin
          if (uc_ready) begin
            r_uc_req <= 1'b0;
            r_state  <= c_RESP;
          end
        end
        c_RESP: begin
          if (uc_resp) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_uc_take) begin
      r_uc_addr <= {w_al_addr[AW-1:0], {DCACHE_BYTE_WIDTH{1'b0}}};
      r_uc_mask <= w_al_mask[DCACHE_BYTE-1:0];
      r_uc_data <= w_al_data[DCACHE_BITS-1:0];
    end
  end

  assign uc_req  = r_uc_req;
  assign uc_addr = r_uc_addr;
  assign uc_mask = r_uc_mask;
  assign uc_data = r_uc_data;
`else
  logic w_unused_uc;

  assign w_unc       = '0;
  assign w_idle      = 1'b1;
  assign w_unused_uc = ^{sq_uncache, sb_empty, uc_ready, uc_resp};
  assign uc_req      = 1'b0;
  assign uc_addr     = '0;
  assign uc_mask     = '0;
  assign uc_data     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_commit_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_store_commit_issue                                                |
// | Directed scoreboard bench for store_commit_issue.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_store_commit_issue;
  import store_commit_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sq_valid, sq_uncache, sq_deq, sc_en, sc_uncache;
  logic [63:0] sq_paddr, sq_data, sc_data;
  logic [3:0]  sq_size;
  logic [59:0] sc_addr;
  logic [7:0]  sc_mask;
  logic        sc_conflict, sb_empty, uc_req, uc_ready, uc_resp;
  logic [31:0] uc_addr, uc_data;
  logic [3:0]  uc_mask;

  typedef struct packed {
    logic [1:0]     en;
    aligned_store_t s1;
    aligned_store_t s0;
  } sc_rec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } uc_rec_t;

  localparam sc_rec_t NONE = '0;

  sc_rec_t sc_q[$];
  uc_rec_t uc_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_commit_issue dut (
    .clk(clk), .rst(rst),
    .sq_valid(sq_valid), .sq_paddr(sq_paddr), .sq_size(sq_size),
    .sq_data(sq_data), .sq_uncache(sq_uncache), .sq_deq(sq_deq),
    .sc_en(sc_en), .sc_addr(sc_addr), .sc_mask(sc_mask), .sc_data(sc_data),
    .sc_uncache(sc_uncache), .sc_conflict(sc_conflict), .sb_empty(sb_empty),
    .uc_req(uc_req), .uc_addr(uc_addr), .uc_mask(uc_mask), .uc_data(uc_data),
    .uc_ready(uc_ready), .uc_resp(uc_resp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic sc_rec_t mk(input logic [1:0] en,
                                 input logic [29:0] a0, input logic [3:0] m0, input logic [31:0] d0,
                                 input logic [29:0] a1, input logic [3:0] m1, input logic [31:0] d1);
    sc_rec_t r;
    r.en      = en;
    r.s0.addr = a0; r.s0.mask = m0; r.s0.data = d0;
    r.s1.addr = a1; r.s1.mask = m1; r.s1.data = d1;
    return r;
  endfunction

  task automatic set_slot(input int i, input logic v, input logic u,
                          input logic [31:0] pa, input logic [1:0] sz, input logic [31:0] d);
    sq_valid[i]         = v;
    sq_uncache[i]       = u;
    sq_paddr[i*32 +: 32] = pa;
    sq_size[i*2 +: 2]    = sz;
    sq_data[i*32 +: 32]  = d;
  endtask

  task automatic clear_slots();
    sq_valid   = 2'b00;
    sq_uncache = 2'b00;
  endtask

  // One cycle: check deq/uc_req mid-cycle, queue what sc_* must show next cycle.
  task automatic cyc(input string name, input logic [1:0] exp_deq, input logic exp_uc, input sc_rec_t nxt);
    @(negedge clk);
    check({name, "_deq"}, {62'd0, sq_deq}, {62'd0, exp_deq});
    check({name, "_ucreq"}, {63'd0, uc_req}, {63'd0, exp_uc});
    if (nxt.en != 2'b00) sc_q.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_sc
    sc_rec_t e;
    sc_rec_t a;
    if (rst === 1'b0 && sc_en != 2'b00) begin
      a.en = sc_en;
      a.s0 = {sc_addr[29:0],  sc_mask[3:0], sc_data[31:0]};
      a.s1 = {sc_addr[59:30], sc_mask[7:4], sc_data[63:32]};
      checks++;
      if (sc_q.size() == 0) begin
        errors++;
        $display("FAIL sc_out: got en=%b s0=%h s1=%h, expected no write", a.en, a.s0, a.s1);
      end else begin
        e = sc_q.pop_front();
        if (!((e.en === a.en) && (!e.en[0] || e.s0 === a.s0) && (!e.en[1] || e.s1 === a.s1))) begin
          errors++;
          $display("FAIL sc_out: got en=%b s0=%h s1=%h, expected en=%b s0=%h s1=%h",
                   a.en, a.s0, a.s1, e.en, e.s0, e.s1);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_uc
    uc_rec_t e;
    uc_rec_t a;
    if (rst === 1'b0 && uc_req === 1'b1) begin
      a = {uc_addr, uc_mask, uc_data};
      checks++;
      if (uc_q.size() == 0) begin
        errors++;
        $display("FAIL uc_out: got %h, expected no request", a);
      end else begin
        e = uc_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL uc_out: got %h, expected %h", a, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sq_paddr = '0; sq_data = '0; sq_size = '0;
    clear_slots();
    sc_conflict = 1'b0; sb_empty = 1'b1; uc_ready = 1'b0; uc_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_sc_en", {62'd0, sc_en}, 64'd0);
    check("rst_uc_req", {63'd0, uc_req}, 64'd0);
    @(posedge clk); #1;

    // Two cached stores in one cycle.
    set_slot(0, 1'b1, 1'b0, 32'h1002, 2'd1, 32'h0000BEEF);
    set_slot(1, 1'b1, 1'b0, 32'h1004, 2'd0, 32'h00000055);
    cyc("two", 2'b11, 1'b0, mk(2'b11, 30'h400, 4'b1100, 32'hBEEF0000, 30'h401, 4'b0001, 32'h00000055));
    clear_slots();
    cyc("idle0", 2'b00, 1'b0, NONE);

    // A single store, then three stalled cycles that must hold it.
    set_slot(0, 1'b1, 1'b0, 32'h1001, 2'd0, 32'h000000A5);
    cyc("pre", 2'b01, 1'b0, mk(2'b01, 30'h400, 4'b0010, 32'h0000A500, 30'h0, 4'h0, 32'h0));
    set_slot(0, 1'b1, 1'b0, 32'h1002, 2'd1, 32'h0000BEEF);
    set_slot(1, 1'b1, 1'b0, 32'h1004, 2'd0, 32'h00000055);
    sc_conflict = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc("conf", 2'b00, 1'b0, mk(2'b01, 30'h400, 4'b0010, 32'h0000A500, 30'h0, 4'h0, 32'h0));
    sc_conflict = 1'b0;
    cyc("resume", 2'b11, 1'b0, mk(2'b11, 30'h400, 4'b1100, 32'hBEEF0000, 30'h401, 4'b0001, 32'h00000055));
    clear_slots();
    cyc("idle1", 2'b00, 1'b0, NONE);

`ifdef UNCACHE_STORE_EN
    // Cached slot 0 goes, uncached slot 1 blocks; next cycle it enters the FSM.
    set_slot(0, 1'b1, 1'b0, 32'h1008, 2'd2, 32'h11112222);
    set_slot(1, 1'b1, 1'b1, 32'h3008, 2'd2, 32'hCAFEF00D);
    cyc("mix", 2'b01, 1'b0, mk(2'b01, 30'h402, 4'b1111, 32'h11112222, 30'h0, 4'h0, 32'h0));
    clear_slots();
    set_slot(0, 1'b1, 1'b1, 32'h3008, 2'd2, 32'hCAFEF00D);
    cyc("uc_take", 2'b01, 1'b0, NONE);
    clear_slots();
    for (int k = 0; k < 5; k++) uc_q.push_back({32'h3008, 4'b1111, 32'hCAFEF00D});
    cyc("drain0", 2'b00, 1'b0, NONE);
    cyc("drain1", 2'b00, 1'b0, NONE);
    for (int k = 0; k < 4; k++) cyc("req_wait", 2'b00, 1'b1, NONE);
    uc_ready = 1'b1;
    cyc("req_acc", 2'b00, 1'b1, NONE);
    uc_ready = 1'b0;
    uc_resp  = 1'b1;
    set_slot(0, 1'b1, 1'b0, 32'h100C, 2'd2, 32'h0000ABCD);
    cyc("resp", 2'b00, 1'b0, NONE);
    uc_resp = 1'b0;
    cyc("after_uc", 2'b01, 1'b0, mk(2'b01, 30'h403, 4'b1111, 32'h0000ABCD, 30'h0, 4'h0, 32'h0));
    clear_slots();
    cyc("idle2", 2'b00, 1'b0, NONE);

    // Reset while waiting for the response abandons the store.
    set_slot(0, 1'b1, 1'b1, 32'h3010, 2'd2, 32'h0BADBEEF);
    cyc("uc2_take", 2'b01, 1'b0, NONE);
    clear_slots();
    uc_q.push_back({32'h3010, 4'b1111, 32'h0BADBEEF});
    cyc("uc2_drain0", 2'b00, 1'b0, NONE);
    cyc("uc2_drain1", 2'b00, 1'b0, NONE);
    uc_ready = 1'b1;
    cyc("uc2_req", 2'b00, 1'b1, NONE);
    uc_ready = 1'b0;
    rst = 1'b1;
    cyc("uc2_rst", 2'b00, 1'b0, NONE);
    rst = 1'b0;
    check("post_rst_sc_en", {62'd0, sc_en}, 64'd0);
    check("post_rst_uc_req", {63'd0, uc_req}, 64'd0);
    uc_resp = 1'b1;
    set_slot(0, 1'b1, 1'b0, 32'h1010, 2'd0, 32'h00000077);
    cyc("post_rst", 2'b01, 1'b0, mk(2'b01, 30'h404, 4'b0001, 32'h00000077, 30'h0, 4'h0, 32'h0));
    clear_slots();
    cyc("stray_resp", 2'b00, 1'b0, NONE);
    uc_resp = 1'b0;
    cyc("idle3", 2'b00, 1'b0, NONE);
`else
    // Uncached flag is ignored: the store commits like any other.
    set_slot(0, 1'b1, 1'b1, 32'h2000, 2'd2, 32'h12345678);
    cyc("nouc", 2'b01, 1'b0, mk(2'b01, 30'h800, 4'b1111, 32'h12345678, 30'h0, 4'h0, 32'h0));
    clear_slots();
    cyc("nouc_idle", 2'b00, 1'b0, NONE);
    check("nouc_uc_out", {uc_addr, uc_data}, 64'd0);
    check("nouc_uc_mask", {60'd0, uc_mask}, 64'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sc_q_drained", 64'(sc_q.size()), 64'd0);
    check("uc_q_drained", 64'(uc_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
